// File: rtl/iomem_wb_pkg.sv
// Shared definitions for the iomem-to-Wishbone bridge: bus widths, FSM
// state encoding, the default error read-back word and the byte-select helper.
package iomem_wb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_BUS  = 2'd1;
  localparam logic [1:0] ENC_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    BUS  = ENC_BUS,
    RESP = ENC_RESP
  } state_t;

  // A read (no strobes) fetches the whole word; a write selects only its strobed bytes.
  function automatic logic [STRB_W-1:0] sel_from_wstrb(input logic [STRB_W-1:0] wstrb);
    return (|wstrb) ? wstrb : {STRB_W{1'b1}};
  endfunction

endpackage

// File: rtl/iomem_wb_bridge_if.sv
// Bus interfaces seen by the bridge: the processor iomem port and the
// Wishbone B4 classic bus. The master modport belongs to the initiator side.
interface iomem_if;
  import iomem_wb_pkg::*;

  logic              valid;
  logic              ready;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
  modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface

interface wb_if;
  import iomem_wb_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [STRB_W-1:0] sel;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              ack;
  logic              err;

  modport master (output cyc, stb, we, adr, sel, dat_w, input  dat_r, ack, err);
  modport slave  (input  cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/iomem_wb_timeout.sv
// Watchdog for an outstanding Wishbone cycle. The counter restarts when a
// transfer is launched and advances once per bus cycle; expire is raised during
// the TIMEOUT_CYCLES-th bus cycle so the FSM can abort on that edge.
module iomem_wb_timeout #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] count_q;

  // Count bus cycles of the current transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     count_q <= '0;
    else if (clear)  count_q <= '0;
    else if (enable) count_q <= count_q + 16'd1;
  end

  assign expire = enable && (count_q == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/iomem_wb_bridge.sv
// iomem-to-Wishbone B4 classic bridge, one outstanding transfer.
// Request is captured in IDLE, driven on the bus from registers in BUS, and
// answered with a single-cycle ready pulse in RESP. All outputs are registered.
// Optional watchdog: define IOMEM_WB_TIMEOUT_EN to abort cycles that see no
// ack/err within TIMEOUT_CYCLES bus cycles.
module iomem_wb_bridge
  import iomem_wb_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  iomem_if.slave            iomem,
  wb_if.master              wb,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] bus_err_addr_o
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("iomem_wb_bridge: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [STRB_W-1:0] sel_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic              term_ack;
  logic              term_err;
  logic              timeout_expire;

`ifdef IOMEM_WB_TIMEOUT_EN
  iomem_wb_timeout #(
    .TIMEOUT_CYCLES (16'(TIMEOUT_CYCLES))
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == IDLE && iomem.valid),
    .enable (state == BUS),
    .expire (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and termination decode; err outranks ack, and any real
  // termination outranks the watchdog.
  always_comb begin
    state_nxt = state;
    term_ack  = 1'b0;
    term_err  = 1'b0;
    case (state)
      IDLE: if (iomem.valid) state_nxt = BUS;
      BUS: begin
        if (wb.err) begin
          term_err  = 1'b1;
          state_nxt = RESP;
        end else if (wb.ack) begin
          term_ack  = 1'b1;
          state_nxt = RESP;
        end else if (timeout_expire) begin
          term_err  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, read data and error bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (state == IDLE && iomem.valid) begin
        adr_q <= iomem.addr;
        dat_q <= iomem.wdata;
        sel_q <= sel_from_wstrb(iomem.wstrb);
        we_q  <= |iomem.wstrb;
        err_q <= 1'b0;
      end
      if (term_err) begin
        rdata_q    <= ERR_RDATA;
        err_q      <= 1'b1;
        err_addr_q <= adr_q;
      end else if (term_ack && !we_q) begin
        rdata_q <= wb.dat_r;
      end
    end
  end

  assign wb.cyc   = (state == BUS);
  assign wb.stb   = (state == BUS);
  assign wb.we    = we_q;
  assign wb.adr   = adr_q;
  assign wb.sel   = sel_q;
  assign wb.dat_w = dat_q;

  assign iomem.ready    = (state == RESP);
  assign iomem.rdata    = rdata_q;
  assign bus_err_o      = (state == RESP) && err_q;
  assign bus_err_addr_o = err_addr_q;

endmodule

// File: doc/iomem_wb_bridge.md
# iomem_wb_bridge

Bridges the processor's native iomem request port (valid/ready, byte strobes) to a Wishbone B4 classic master for the off-core peripheral and memory fabric. It sits directly downstream of the processor top: it consumes `iomem_valid/wstrb/addr/wdata` and returns `iomem_ready/rdata`. It supports one outstanding transfer. It adds registered request capture, bus-error reporting and an optional watchdog timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: Wishbone cycles to wait for ack/err before aborting; legal range 1..65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: value returned on `iomem_rdata` for a failed transfer.

- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `iomem_valid`  in  1  request from the processor; held until `iomem_ready`.
- `iomem_ready`  out  1  one-cycle completion pulse.
- `iomem_wstrb`  in  4  byte strobes; 0 means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data; valid while `iomem_ready` is high.
- `wb_cyc_o`, `wb_stb_o`  out  1  Wishbone cycle and strobe; always equal.
- `wb_we_o`  out  1  write enable.
- `wb_adr_o`  out  32  address; forwarded unaltered.
- `wb_sel_o`  out  4  byte selects.
- `wb_dat_o`  out  32  write data.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`  in  1  slave termination.
- `bus_err_o`  out  1  one-cycle pulse on an error or timeout completion.
- `bus_err_addr_o`  out  32  address of the last failed transfer; holds until the next failure.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE, `iomem_valid`=1:
  - Latch addr, wdata and wstrb.
  - `we` = |wstrb.
  - `sel` = wstrb for a write, 4'hF for a read.
  - Go to BUS.
- BUS:
  - `wb_cyc_o`/`wb_stb_o` = 1, driven from the latched registers.
  - `wb_ack_i`=1: capture `wb_dat_i` into the rdata register (reads only; writes keep the previous rdata), then go to RESP.
  - `wb_err_i`=1: rdata := `ERR_RDATA`, set the error flag, go to RESP.
  - Both ack and err in the same cycle: err wins.
- RESP:
  - `iomem_ready`=1 for exactly one cycle.
  - `bus_err_o` = error flag for the same cycle; `bus_err_addr_o` is updated on that cycle.
  - Go to IDLE.
- `wb_cyc_o` is deasserted on the clock edge after the termination; the bridge never holds cyc across transfers.
- Terminations arriving while not in BUS are ignored.
- `iomem_valid` falling while in BUS (protocol violation) does not abort the transfer; completion proceeds normally.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - All outputs go to 0: `iomem_ready`, `iomem_rdata`, all `wb_*_o`, `bus_err_o`, `bus_err_addr_o`.

## Timing
- Cycle 0: `iomem_valid` is sampled in IDLE.
- Cycle 1: stb is high.
- Ack at cycle k≥1: `iomem_ready` and rdata appear at cycle k+1. Minimum latency is 2 cycles from valid to ready.
- Earliest re-accept is the cycle after ready; the processor drops valid on the ready edge, so no duplicate issue occurs.
- Throughput: at most one transfer per 3 cycles.
- Outputs are fully registered; there is no combinational path from `wb_*_i` to `iomem_*`.

## Configuration
- `IOMEM_WB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle.
  - When the counter reaches `TIMEOUT_CYCLES` with no termination, the transfer completes exactly as `wb_err_i`: cyc/stb drop, RESP, `ERR_RDATA`, `bus_err_o` pulse.
  - A termination arriving in that same cycle takes precedence over the timeout.
- `IOMEM_WB_TIMEOUT_EN` undefined: no counter; BUS waits indefinitely; `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `iomem_wb_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, BUS=2'd1, RESP=2'd2);
  - the `ERR_RDATA` default constant;
  - the width constants (address 32, data 32, strobe 4).
- One sub-module: `iomem_wb_timeout` (counter, clear, expire output). It is instantiated only under `IOMEM_WB_TIMEOUT_EN`.

## Test plan
- Read at 0x3000_0010, slave acks 2 cycles after stb with 0x1234_5678 -> `wb_sel_o`=4'hF, `wb_we_o`=0; `iomem_rdata`=0x1234_5678 with ready at cycle 4; `bus_err_o`=0.
- Write 0xAABB_CCDD with wstrb 4'b0011, same-cycle ack -> `wb_we_o`=1, `wb_sel_o`=4'b0011, `wb_dat_o`=0xAABB_CCDD; ready at cycle 2.
- `wb_err_i`=1 on address 0x4000_0000 -> `iomem_rdata`=0xDEAD_BEEF; `bus_err_o` pulses one cycle; `bus_err_addr_o`=0x4000_0000.
- `wb_ack_i` and `wb_err_i` high together -> treated as an error; rdata=`ERR_RDATA`.
- With the macro defined, `TIMEOUT_CYCLES`=8 and no slave response -> cyc drops after 8 BUS cycles; ready plus a `bus_err_o` pulse follow; a late ack is ignored.
- `resetn` low during BUS -> all outputs 0 immediately; after release a new read completes normally.
